// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one byte-masked memory port among NUM_REQ requesters,
// with hold back-pressure and per-requester lock. Define MEM_ARB_STATS_EN for the contention counter.
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_BYTE  = 8,
  parameter int unsigned ADDR_SIZE  = 32,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_REQ-1:0]               useEnable_i,
  input  logic [NUM_REQ-1:0]               useIsWrite_i,
  input  logic [NUM_REQ-1:0]               useLock_i,
  input  logic [NUM_REQ*DATA_BYTE-1:0]     useWriteMask_i,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]     useAddr_i,
  input  logic [NUM_REQ*DATA_BYTE*8-1:0]   useWriteData_i,
  output logic [NUM_REQ*DATA_BYTE*8-1:0]   useReadData_o,
  output logic [NUM_REQ-1:0]               useReadValid_o,
  output logic [NUM_REQ-1:0]               useHold_o,
  output logic                             memEnable_o,
  output logic                             memIsWrite_o,
  output logic [DATA_BYTE-1:0]             memWriteMask_o,
  output logic [ADDR_SIZE-1:0]             memAddr_o,
  output logic [DATA_BYTE*8-1:0]           memWriteData_o,
  input  logic [DATA_BYTE*8-1:0]           memReadData_i,
  input  logic                             memHold_i,
  input  logic                             statClear_i,
  output logic [STAT_WIDTH-1:0]            statWait_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned DW    = DATA_BYTE * 8;

  typedef enum logic [1:0] {IDLE, BUSY, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] rd_owner_q, rd_owner_d;
  logic             rd_valid_q, rd_valid_d;

  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] cand;
  logic             accept;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (32'(i) == NUM_REQ - 1) ? '0 : i + IDX_W'(1);
  endfunction

  // Nothing is selected while in reset, which forces mem outputs low and hold = enable.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    if (rst_ni) begin
      if (state_q == IDLE) begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
          if (!sel_valid && useEnable_i[cand]) begin
            sel_valid = 1'b1;
            sel_idx   = cand;
          end
        end
      end else begin
        sel_valid = 1'b1;
        sel_idx   = owner_q;
      end
    end
  end

  always_comb begin
    memEnable_o    = 1'b0;
    memIsWrite_o   = 1'b0;
    memWriteMask_o = '0;
    memAddr_o      = '0;
    memWriteData_o = '0;
    if (sel_valid) begin
      memEnable_o    = useEnable_i[sel_idx];
      memIsWrite_o   = useIsWrite_i[sel_idx];
      memWriteMask_o = useWriteMask_i[32'(sel_idx)*DATA_BYTE +: DATA_BYTE];
      memAddr_o      = useAddr_i[32'(sel_idx)*ADDR_SIZE +: ADDR_SIZE];
      memWriteData_o = useWriteData_i[32'(sel_idx)*DW +: DW];
    end
    accept = sel_valid & useEnable_i[sel_idx] & ~memHold_i;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      useHold_o[i] = useEnable_i[i] & ~(sel_valid & (sel_idx == IDX_W'(i)) & ~memHold_i);
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    rd_valid_d = accept & ~useIsWrite_i[sel_idx];
    rd_owner_d = (accept & ~useIsWrite_i[sel_idx]) ? sel_idx : rd_owner_q;
    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          if (memHold_i) begin
            state_d = BUSY;
            owner_d = sel_idx;
          end else if (useLock_i[sel_idx]) begin
            state_d = LOCKED;
            owner_d = sel_idx;
          end else begin
            rr_ptr_d = next_idx(sel_idx);
          end
        end
      end
      BUSY: begin
        // An owner abandoning its stalled request forfeits without advancing the pointer.
        if (!useEnable_i[owner_q]) begin
          state_d = IDLE;
        end else if (!memHold_i) begin
          if (useLock_i[owner_q]) begin
            state_d = LOCKED;
          end else begin
            state_d  = IDLE;
            rr_ptr_d = next_idx(owner_q);
          end
        end
      end
      LOCKED: begin
        if (!useLock_i[owner_q] && (!useEnable_i[owner_q] || !memHold_i)) begin
          state_d  = IDLE;
          rr_ptr_d = next_idx(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      rd_owner_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      rd_owner_q <= rd_owner_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    useReadValid_o = '0;
    useReadData_o  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rd_valid_q && (rd_owner_q == IDX_W'(i))) begin
        useReadValid_o[i]         = 1'b1;
        useReadData_o[i*DW +: DW] = memReadData_i;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stat_q, stat_d;
  logic                  contention;

  always_comb begin
    contention = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_valid && (sel_idx != IDX_W'(i)) && useEnable_i[i]) contention = 1'b1;
    end
    stat_d = stat_q;
    if (statClear_i) begin
      stat_d = '0;
    end else if (contention && (stat_q != '1)) begin
      stat_d = stat_q + STAT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stat_q <= '0;
    else         stat_q <= stat_d;
  end

  assign statWait_o = stat_q;
`else
  logic stat_clear_unused;
  assign stat_clear_unused = statClear_i;
  assign statWait_o        = '0;
`endif

endmodule
